// File: rtl/inst_queue.sv
// Instruction prefetch queue: a DEPTH-entry circular buffer of {instr, pc4} between fetch and decode.
// Show-ahead head output, registered-count handshakes, flush discards everything and tallies the drops.
module inst_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc4,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc4,
  output logic [CNT_W-1:0] count,
  output logic [15:0]      flush_drops
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [15:0]      drops_q;
  logic [63:0]      head;
  logic             enq;
  logic             deq;
  logic [16:0]      drops_sum;

  // Ready/valid come only from the registered count, so there is no out_ready -> in_ready path.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign enq       = in_valid && in_ready && !flush;
  assign deq       = out_valid && out_ready && !flush;

  assign head      = mem[rd_ptr];
  assign out_instr = out_valid ? head[63:32] : 32'h0;
  assign out_pc4   = out_valid ? head[31:0]  : 32'h0;

  assign count       = count_q;
  assign flush_drops = drops_q;
  assign drops_sum   = {1'b0, drops_q} + 17'(count_q);

  // Storage is intentionally left out of reset; only the bookkeeping below is cleared.
  always_ff @(posedge clock) begin
    if (enq) begin
      mem[wr_ptr] <= {in_instr, in_pc4};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      drops_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      drops_q <= drops_sum[16] ? 16'hFFFF : drops_sum[15:0];
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (enq && !deq) begin
        count_q <= count_q + CNT_W'(1);
      end else if (deq && !enq) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule
